// File: rtl/param_alu_ctrl.sv
// Multi-cycle ALU controller: IDLE -> CALC -> DONE handshake; MUL is a shift-add over WIDTH cycles.
// Define ALU_FLAGS_EN to add the registered flags[2:0] = {ovf, carry, zero} output.
module param_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               ok,
  input  logic               ack,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic               done
`ifdef ALU_FLAGS_EN
  ,
  output logic [2:0]         flags
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_NOR = 3'b101,
    OP_XOR = 3'b110,
    OP_SUB = 3'b111
  } op_e;

  state_e             r_state;
  state_e             w_next;
  op_e                r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_out;

  logic               w_start;
  logic               w_calc_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_result;

  assign w_start     = (r_state == S_IDLE) && ok && (op != OP_NOP);
  // MUL finishes on the cycle that consumes the last multiplier bit; everything else takes one cycle.
  assign w_calc_last = (r_op != OP_MUL) || (r_cnt == CW'(WIDTH - 1));

  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_ADD:  w_result = {{(WIDTH-1){1'b0}}, w_sum};
      OP_SUB:  w_result = {{(WIDTH-1){1'b0}}, w_diff};
      OP_MUL:  w_result = w_acc_next;
      OP_AND:  w_result = {{WIDTH{1'b0}}, r_a & r_b};
      OP_OR:   w_result = {{WIDTH{1'b0}}, r_a | r_b};
      OP_NOR:  w_result = {{WIDTH{1'b0}}, ~(r_a | r_b)};
      OP_XOR:  w_result = {{WIDTH{1'b0}}, r_a ^ r_b};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_CALC;
      S_CALC:  if (w_calc_last) w_next = S_DONE;
      S_DONE:  if (ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_NOP;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
    end else if (w_start) begin
      r_op     <= op_e'(op);
      r_a      <= a_in;
      r_b      <= b_in;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a_in};
      r_mplier <= b_in;
      r_cnt    <= '0;
    end else if (r_state == S_CALC) begin
      if (r_op == OP_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (w_calc_last) begin
        r_out <= w_result;
      end
    end
  end

  assign out  = r_out;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

`ifdef ALU_FLAGS_EN
  logic [2:0] r_flags;
  logic       w_ovf;
  logic       w_carry;

  always_comb begin
    w_ovf   = 1'b0;
    w_carry = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_carry = w_diff[WIDTH];
        w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      default: begin
        w_ovf   = 1'b0;
        w_carry = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if ((r_state == S_CALC) && w_calc_last) begin
      r_flags <= {w_ovf, w_carry, (w_result == '0)};
    end
  end

  assign flags = r_flags;
`endif

endmodule

// File: tb/tb_param_alu_ctrl.sv
// Self-checking bench for param_alu_ctrl (WIDTH=8): directed vector table, handshake corner
// sequences and randomized operations against an arithmetic reference model.
module tb_param_alu_ctrl;

  localparam int W = 8;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SUB = 3'b111;

  logic           clk;
  logic           rst_n;
  logic [2:0]     op;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           ok;
  logic           ack;
  logic [2*W-1:0] out;
  logic           busy;
  logic           done;
`ifdef ALU_FLAGS_EN
  logic [2:0]     flags;
`endif

  param_alu_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (op),
    .a_in  (a_in),
    .b_in  (b_in),
    .ok    (ok),
    .ack   (ack),
    .out   (out),
    .busy  (busy),
    .done  (done)
`ifdef ALU_FLAGS_EN
    ,
    .flags (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_out;
    logic [2:0]     exp_fl;
  } vec_t;

  int unsigned    n_cmp;
  int unsigned    n_err;
  logic [2*W-1:0] m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the opcode definitions, using wide integer arithmetic.
  function automatic void model(input logic [2:0] o, input longint unsigned a, input longint unsigned b,
                                output logic [2*W-1:0] r, output logic [2:0] f);
    longint unsigned m = 64'd1 << W;
    longint unsigned res = 0;
    longint sa = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
    longint sb = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
    longint ss = 0;
    logic ovf = 1'b0;
    logic cy = 1'b0;
    case (o)
      OP_ADD: begin
        res = a + b;
        cy  = (res >= m);
        ss  = sa + sb;
        ovf = (ss > longint'(m / 2) - 1) || (ss < -longint'(m / 2));
      end
      OP_SUB: begin
        res = (a >= b) ? a - b : (a + m - b) + m;
        cy  = (a < b);
        ss  = sa - sb;
        ovf = (ss > longint'(m / 2) - 1) || (ss < -longint'(m / 2));
      end
      OP_MUL:  res = a * b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOR:  res = ~(a | b) & (m - 1);
      OP_XOR:  res = a ^ b;
      default: res = 0;
    endcase
    r = res[2*W-1:0];
    f = {ovf, cy, (res == 0)};
  endfunction

  task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp_out, input logic [2:0] exp_fl,
                       input int hold, input bit noise, input bit do_ack);
    int lat;
    int exp_lat;
    exp_lat = (o == OP_MUL) ? W : 1;
    op = o; a_in = a; b_in = b; ok = 1'b1; ack = 1'b0;
    @(posedge clk); #1;
    ok = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); op = 3'($urandom);
    chk({tag, "/busy_after_capture"}, 64'(busy), 64'd1);
    lat = 0;
    do begin
      chk({tag, "/out_stable_in_calc"}, 64'(out), 64'(m_last));
      if (noise) begin
        ok  = 1'($urandom_range(0, 1));
        ack = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < W + 4);
    ok = 1'b0; ack = 1'b0;
    chk({tag, "/done"}, 64'(done), 64'd1);
    chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "/out"}, 64'(out), 64'(exp_out));
    chk({tag, "/busy_in_done"}, 64'(busy), 64'd1);
`ifdef ALU_FLAGS_EN
    chk({tag, "/flags"}, 64'(flags), 64'(exp_fl));
`else
    if (exp_fl === 3'bxxx) $display("note: undefined flag expectation in %s", tag);
`endif
    repeat (hold) begin
      if (noise) ok = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk({tag, "/held_out"}, 64'(out), 64'(exp_out));
      chk({tag, "/held_done"}, 64'(done), 64'd1);
    end
    m_last = exp_out;
    if (do_ack) begin
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0; ok = 1'b0;
      chk({tag, "/idle_after_ack"}, 64'({busy, done}), 64'd0);
      chk({tag, "/out_kept_in_idle"}, 64'(out), 64'(exp_out));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    logic [2*W-1:0] r;
    logic [2:0]     f;
    logic [2:0]     o;
    logic [W-1:0]   a;
    logic [W-1:0]   b;

    tbl[0]  = '{OP_ADD, 8'hFF, 8'h01, 16'h0100, 3'b010};
    tbl[1]  = '{OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 3'b000};
    tbl[2]  = '{OP_SUB, 8'h03, 8'h05, 16'h01FE, 3'b010};
    tbl[3]  = '{OP_NOR, 8'hF0, 8'h0F, 16'h0000, 3'b001};
    tbl[4]  = '{OP_AND, 8'hCC, 8'hAA, 16'h0088, 3'b000};
    tbl[5]  = '{OP_OR,  8'h0C, 8'h30, 16'h003C, 3'b000};
    tbl[6]  = '{OP_XOR, 8'h55, 8'h55, 16'h0000, 3'b001};
    tbl[7]  = '{OP_ADD, 8'h7F, 8'h01, 16'h0080, 3'b100};
    tbl[8]  = '{OP_SUB, 8'h80, 8'h01, 16'h007F, 3'b100};
    tbl[9]  = '{OP_ADD, 8'h80, 8'h80, 16'h0100, 3'b110};
    tbl[10] = '{OP_MUL, 8'h00, 8'h37, 16'h0000, 3'b001};
    tbl[11] = '{OP_MUL, 8'h0D, 8'h0B, 16'h008F, 3'b000};
    tbl[12] = '{OP_SUB, 8'h05, 8'h05, 16'h0000, 3'b001};
    tbl[13] = '{OP_MUL, 8'h80, 8'h02, 16'h0100, 3'b000};

    n_cmp = 0; n_err = 0; m_last = '0;
    rst_n = 1'b1; ok = 1'b0; ack = 1'b0; op = OP_NOP; a_in = '0; b_in = '0;

    // Reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset/out", 64'(out), 64'd0);
    chk("reset/busy_done", 64'({busy, done}), 64'd0);
`ifdef ALU_FLAGS_EN
    chk("reset/flags", 64'(flags), 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table; first entry also captures on the first edge after reset release.
    for (int i = 0; i < 14; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_out, tbl[i].exp_fl, 2, 1'b0, 1'b1);
    end

    // NOP with ok held high: stays idle, out untouched.
    ok = 1'b1; op = OP_NOP; a_in = 8'h12; b_in = 8'h34;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("nop/busy_done", 64'({busy, done}), 64'd0);
      chk("nop/out", 64'(out), 64'(m_last));
    end
    ok = 1'b0;

    // XOR result must not follow operand changes made while in DONE.
    do_op("xor_hold", OP_XOR, 8'h3C, 8'h0F, 16'h0033, 3'b000, 0, 1'b0, 1'b0);
    a_in = 8'hFF; b_in = 8'h00; op = OP_ADD;
    @(posedge clk); #1;
    chk("xor_hold/out_after_input_change", 64'(out), 64'h0033);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("xor_hold/idle", 64'({busy, done}), 64'd0);

    // Reset during the 4th CALC cycle of a MUL.
    op = OP_MUL; a_in = 8'hFF; b_in = 8'hFF; ok = 1'b1;
    @(posedge clk); #1;
    ok = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst/busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst/out_async", 64'(out), 64'd0);
    chk("midrst/busy_done_async", 64'({busy, done}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = '0;
    repeat (W + 2) begin @(posedge clk); #1; end
    chk("midrst/no_result_busy_done", 64'({busy, done}), 64'd0);
    chk("midrst/no_result_out", 64'(out), 64'd0);
    do_op("post_rst_add", OP_ADD, 8'h10, 8'h20, 16'h0030, 3'b000, 1, 1'b0, 1'b1);

    // ok and ack together in DONE: ack wins, capture only on the following edge.
    do_op("okack_first", OP_ADD, 8'h01, 8'h02, 16'h0003, 3'b000, 0, 1'b0, 1'b0);
    op = OP_SUB; a_in = 8'h09; b_in = 8'h04; ok = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("okack/idle_no_capture", 64'({busy, done}), 64'd0);
    chk("okack/out_kept", 64'(out), 64'h0003);
    do_op("okack_second", OP_SUB, 8'h09, 8'h04, 16'h0005, 3'b000, 0, 1'b0, 1'b1);

    // Randomized operations with ok/ack noise, checked against the model.
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(1, 7));
      case ($urandom_range(0, 5))
        0:       begin a = '1; b = W'($urandom); end
        1:       begin a = W'($urandom); b = '0; end
        default: begin a = W'($urandom); b = W'($urandom); end
      endcase
      model(o, longint'(a), longint'(b), r, f);
      if ($urandom_range(0, 7) == 0) begin
        op = OP_NOP; ok = 1'b1;
        @(posedge clk); #1;
        ok = 1'b0;
        chk("rand/nop_idle", 64'({busy, done, out}), 64'({2'b00, m_last}));
      end
      do_op($sformatf("rand%0d", i), o, a, b, r, f, $urandom_range(0, 2), 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
